// File: rtl/fall_engine_if.sv
// rtl/fall_engine_if.sv - handshake and character-RAM write bundle of the falling-character engine
interface fall_engine_if;
  logic        tick;
  logic        spawn_valid;
  logic [7:0]  spawn_ascii;
  logic [6:0]  spawn_col;
  logic        spawn_ready;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic        key_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic        hit;
  logic        typo;
  logic        miss;
  logic [3:0]  active;

  modport master (
    output tick, spawn_valid, spawn_ascii, spawn_col, key_valid, key_ascii,
    input  spawn_ready, key_ready, wr_en, wr_addr, wr_data, hit, typo, miss, active
  );

  modport slave (
    input  tick, spawn_valid, spawn_ascii, spawn_col, key_valid, key_ascii,
    output spawn_ready, key_ready, wr_en, wr_addr, wr_data, hit, typo, miss, active
  );
endinterface

// File: rtl/fall_engine.sv
// rtl/fall_engine.sv - falling-character state machine that owns the text-mode character RAM write port
// Outputs are registered on the transition into the write state, so wr_en is high while in ERASE/DRAW/KILL/PLACE.
module fall_engine #(
  parameter int COLS  = 70,
  parameter int ROWS  = 30,
  parameter int SLOTS = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  fall_engine_if.slave bus
);
  localparam int              KW         = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [11:0]     COLS_W     = 12'(COLS);
  localparam logic [4:0]      LAST_ROW   = 5'(ROWS - 1);
  localparam logic [6:0]      LAST_COL   = 7'(COLS - 1);
  localparam logic [KW-1:0]   LAST_K     = KW'(SLOTS - 1);
  localparam logic [3:0]      MAX_ACTIVE = 4'(SLOTS);

  typedef enum logic [2:0] {IDLE, SCAN, ERASE, DRAW, KILL, PLACE} state_t;

  state_t           r_state, w_state;
  logic [KW-1:0]    r_k, w_k;
  logic             r_tick_pending, w_tick_pending;
  logic [SLOTS-1:0] r_valid, w_valid;
  logic [4:0]       r_row   [SLOTS];
  logic [4:0]       w_row   [SLOTS];
  logic [6:0]       r_col   [SLOTS];
  logic [6:0]       w_col   [SLOTS];
  logic [7:0]       r_ascii [SLOTS];
  logic [7:0]       w_ascii [SLOTS];

  logic             r_wr_en, w_wr_en;
  logic [11:0]      r_wr_addr, w_wr_addr;
  logic [7:0]       r_wr_data, w_wr_data;
  logic             r_hit, w_hit;
  logic             r_typo, w_typo;
  logic             r_miss, w_miss;
  logic [3:0]       r_active, w_active;

  logic             w_key_ready;
  logic             w_spawn_ready;
  logic             w_match_found;
  logic [KW-1:0]    w_match_idx;
  logic             w_free_found;
  logic [KW-1:0]    w_free_idx;
  logic [6:0]       w_spawn_col;
  logic             w_last_k;

  function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
    return 12'(row) * COLS_W + 12'(col);
  endfunction

  assign w_key_ready   = (r_state == IDLE) && !bus.tick && !r_tick_pending;
  assign w_spawn_ready = w_key_ready && !bus.key_valid && (r_active < MAX_ACTIVE);
  assign w_spawn_col   = (bus.spawn_col > LAST_COL) ? LAST_COL : bus.spawn_col;
  assign w_last_k      = (r_k == LAST_K);

  assign bus.key_ready   = w_key_ready;
  assign bus.spawn_ready = w_spawn_ready;
  assign bus.wr_en       = r_wr_en;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data     = r_wr_data;
  assign bus.hit         = r_hit;
  assign bus.typo        = r_typo;
  assign bus.miss        = r_miss;
  assign bus.active      = r_active;

  // Scanning downward leaves the lowest matching / free index as the winner.
  always_comb begin
    w_match_found = 1'b0;
    w_match_idx   = '0;
    w_free_found  = 1'b0;
    w_free_idx    = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_ascii[i] == bus.key_ascii)) begin
        w_match_found = 1'b1;
        w_match_idx   = KW'(i);
      end
      if (!r_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = KW'(i);
      end
    end
  end

  always_comb begin
    w_state        = r_state;
    w_k            = r_k;
    w_tick_pending = r_tick_pending;
    w_valid        = r_valid;
    w_row          = r_row;
    w_col          = r_col;
    w_ascii        = r_ascii;
    w_wr_en        = 1'b0;
    w_wr_addr      = '0;
    w_wr_data      = '0;
    w_hit          = 1'b0;
    w_typo         = 1'b0;
    w_miss         = 1'b0;

    if (bus.tick && (r_state != IDLE)) begin
      w_tick_pending = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (bus.tick || r_tick_pending) begin
          w_tick_pending = 1'b0;
          w_k            = '0;
          w_state        = SCAN;
        end else if (bus.key_valid) begin
          if (w_match_found) begin
            w_valid[w_match_idx] = 1'b0;
            w_wr_en              = 1'b1;
            w_wr_addr            = cell_addr(r_row[w_match_idx], r_col[w_match_idx]);
            w_hit                = 1'b1;
            w_state              = KILL;
          end else begin
            w_typo = 1'b1;
          end
        end else if (bus.spawn_valid && w_spawn_ready && w_free_found) begin
          w_valid[w_free_idx] = 1'b1;
          w_row[w_free_idx]   = '0;
          w_col[w_free_idx]   = w_spawn_col;
          w_ascii[w_free_idx] = bus.spawn_ascii;
          w_wr_en             = 1'b1;
          w_wr_addr           = 12'(w_spawn_col);
          w_wr_data           = bus.spawn_ascii;
          w_state             = PLACE;
        end
      end

      SCAN: begin
        if (r_valid[r_k]) begin
          w_wr_en   = 1'b1;
          w_wr_addr = cell_addr(r_row[r_k], r_col[r_k]);
          w_state   = ERASE;
          if (r_row[r_k] == LAST_ROW) begin
            w_valid[r_k] = 1'b0;
            w_miss       = 1'b1;
          end else begin
            w_row[r_k] = r_row[r_k] + 5'd1;
          end
        end else if (w_last_k) begin
          w_state = IDLE;
        end else begin
          w_k = r_k + KW'(1);
        end
      end

      // A slot still valid here was moved down and needs its redraw.
      ERASE: begin
        if (r_valid[r_k]) begin
          w_wr_en   = 1'b1;
          w_wr_addr = cell_addr(r_row[r_k], r_col[r_k]);
          w_wr_data = r_ascii[r_k];
          w_state   = DRAW;
        end else if (w_last_k) begin
          w_state = IDLE;
        end else begin
          w_k     = r_k + KW'(1);
          w_state = SCAN;
        end
      end

      DRAW: begin
        if (w_last_k) begin
          w_state = IDLE;
        end else begin
          w_k     = r_k + KW'(1);
          w_state = SCAN;
        end
      end

      KILL, PLACE: w_state = IDLE;

      default: w_state = IDLE;
    endcase
  end

  always_comb begin
    w_active = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_active = w_active + 4'(w_valid[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_k            <= '0;
      r_tick_pending <= 1'b0;
      r_valid        <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        r_row[i]   <= '0;
        r_col[i]   <= '0;
        r_ascii[i] <= '0;
      end
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_hit     <= 1'b0;
      r_typo    <= 1'b0;
      r_miss    <= 1'b0;
      r_active  <= '0;
    end else begin
      r_state        <= w_state;
      r_k            <= w_k;
      r_tick_pending <= w_tick_pending;
      r_valid        <= w_valid;
      r_row          <= w_row;
      r_col          <= w_col;
      r_ascii        <= w_ascii;
      r_wr_en        <= w_wr_en;
      r_wr_addr      <= w_wr_addr;
      r_wr_data      <= w_wr_data;
      r_hit          <= w_hit;
      r_typo         <= w_typo;
      r_miss         <= w_miss;
      r_active       <= w_active;
    end
  end
endmodule

// File: tb/tb_fall_engine.sv
// tb/tb_fall_engine.sv - directed scoreboard bench for fall_engine
module tb_fall_engine;
  localparam int COLS  = 70;
  localparam int ROWS  = 30;
  localparam int SLOTS = 4;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
    logic        hit;
    logic        miss;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fall_engine_if bus ();

  fall_engine #(.COLS(COLS), .ROWS(ROWS), .SLOTS(SLOTS)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   checks    = 0;
  int   errors    = 0;
  int   typo_seen = 0;
  int   typo_exp  = 0;
  wr_t  sb[$];
  wr_t  mon_e;

  logic       m_valid [SLOTS];
  logic [4:0] m_row   [SLOTS];
  logic [6:0] m_col   [SLOTS];
  logic [7:0] m_ascii [SLOTS];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] addr_of(input logic [4:0] r, input logic [6:0] c);
    return 12'(r) * 12'(COLS) + 12'(c);
  endfunction

  function automatic wr_t mk(input logic [11:0] a, input logic [7:0] d, input logic h, input logic m);
    wr_t e;
    e.addr = a;
    e.data = d;
    e.hit  = h;
    e.miss = m;
    return e;
  endfunction

  function automatic int m_active();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.typo === 1'b1) typo_seen++;
      if (bus.wr_en === 1'b1) begin
        chk("write_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(mon_e.addr));
          chk("wr_data", 32'(bus.wr_data), 32'(mon_e.data));
          chk("hit",     32'(bus.hit),     32'(mon_e.hit));
          chk("miss",    32'(bus.miss),    32'(mon_e.miss));
        end
      end else if (bus.hit !== 1'b0 || bus.miss !== 1'b0) begin
        chk("flag_without_write", 32'({bus.hit, bus.miss}), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < SLOTS; i++) begin
      m_valid[i] = 1'b0;
      m_row[i]   = '0;
      m_col[i]   = '0;
      m_ascii[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_clear();
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.key_ready !== 1'b1) && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_idle"}, 32'(n < 300), 32'd1);
    repeat (3) step();
  endtask

  task automatic model_walk();
    for (int i = 0; i < SLOTS; i++) begin
      if (m_valid[i]) begin
        sb.push_back(mk(addr_of(m_row[i], m_col[i]), 8'h00, 1'b0, m_row[i] == 5'(ROWS - 1)));
        if (m_row[i] == 5'(ROWS - 1)) begin
          m_valid[i] = 1'b0;
        end else begin
          m_row[i] = m_row[i] + 5'd1;
          sb.push_back(mk(addr_of(m_row[i], m_col[i]), m_ascii[i], 1'b0, 1'b0));
        end
      end
    end
  endtask

  task automatic do_spawn(input logic [7:0] a, input logic [6:0] c);
    int n = 0;
    int slot = -1;
    bus.spawn_valid = 1'b1;
    bus.spawn_ascii = a;
    bus.spawn_col   = c;
    #1;
    while (bus.spawn_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("spawn_ready", 32'(bus.spawn_ready), 32'd1);
    for (int i = SLOTS - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
    if (slot >= 0 && bus.spawn_ready === 1'b1) begin
      m_valid[slot] = 1'b1;
      m_row[slot]   = '0;
      m_col[slot]   = (c > 7'(COLS - 1)) ? 7'(COLS - 1) : c;
      m_ascii[slot] = a;
      sb.push_back(mk(12'(m_col[slot]), a, 1'b0, 1'b0));
    end
    step();
    bus.spawn_valid = 1'b0;
  endtask

  task automatic do_key(input logic [7:0] a);
    int n = 0;
    int slot = -1;
    bus.key_valid = 1'b1;
    bus.key_ascii = a;
    #1;
    while (bus.key_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk("key_ready", 32'(bus.key_ready), 32'd1);
    for (int i = SLOTS - 1; i >= 0; i--) if (m_valid[i] && m_ascii[i] == a) slot = i;
    if (slot >= 0) begin
      m_valid[slot] = 1'b0;
      sb.push_back(mk(addr_of(m_row[slot], m_col[slot]), 8'h00, 1'b1, 1'b0));
    end else begin
      typo_exp++;
    end
    step();
    bus.key_valid = 1'b0;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    model_walk();
    step();
    bus.tick = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tick        = 1'b0;
    bus.spawn_valid = 1'b0;
    bus.spawn_ascii = 8'h00;
    bus.spawn_col   = 7'd0;
    bus.key_valid   = 1'b0;
    bus.key_ascii   = 8'h00;
    model_clear();

    // reset state
    step();
    step();
    chk("rst_wr_en",  32'(bus.wr_en),  32'd0);
    chk("rst_hit",    32'(bus.hit),    32'd0);
    chk("rst_typo",   32'(bus.typo),   32'd0);
    chk("rst_miss",   32'(bus.miss),   32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_key_ready",   32'(bus.key_ready),   32'd1);
    chk("rst_spawn_ready", 32'(bus.spawn_ready), 32'd1);

    // spawn 'A' at col 20
    do_spawn(8'h41, 7'd20);
    wait_idle("spawn_a");
    chk("spawn_a_active", 32'(bus.active), 32'd1);

    // tick: erase 20, draw 90, first write two cycles after the tick
    bus.tick = 1'b1;
    model_walk();
    step();
    bus.tick = 1'b0;
    @(negedge clk);
    chk("tick_lat_c1_wr_en", 32'(bus.wr_en), 32'd0);
    @(negedge clk);
    chk("tick_lat_c2_wr_en", 32'(bus.wr_en), 32'd1);
    #1;
    wait_idle("tick_a");
    chk("tick_a_active", 32'(bus.active), 32'd1);
    chk("tick_a_typo", 32'(typo_seen), 32'd0);

    // fall off the bottom row
    do_reset();
    do_spawn(8'h43, 7'd5);
    wait_idle("spawn_c");
    for (int t = 0; t < ROWS - 1; t++) begin
      do_tick();
      wait_idle("fall_c");
    end
    chk("fall_c_active_before", 32'(bus.active), 32'd1);
    bus.tick = 1'b1;
    sb.push_back(mk(12'd2035, 8'h00, 1'b0, 1'b1));
    model_clear();
    step();
    bus.tick = 1'b0;
    wait_idle("miss_c");
    chk("miss_c_active", 32'(bus.active), 32'd0);

    // key hits lowest matching slot; unmatched key is a typo
    do_reset();
    do_spawn(8'h42, 7'd3);
    do_spawn(8'h42, 7'd7);
    wait_idle("spawn_bb");
    chk("bb_active", 32'(bus.active), 32'd2);
    do_key(8'h42);
    wait_idle("key_b");
    chk("key_b_active", 32'(bus.active), 32'd1);
    do_key(8'h5A);
    wait_idle("key_z");
    chk("key_z_typo", 32'(typo_seen), 32'(typo_exp));
    chk("key_z_active", 32'(bus.active), 32'd1);

    // full engine refuses spawns
    do_spawn(8'h44, 7'd10);
    do_spawn(8'h45, 7'd11);
    do_spawn(8'h46, 7'd12);
    wait_idle("fill");
    chk("fill_active", 32'(bus.active), 32'd4);
    bus.spawn_valid = 1'b1;
    bus.spawn_ascii = 8'h47;
    bus.spawn_col   = 7'd1;
    step();
    step();
    chk("full_spawn_ready", 32'(bus.spawn_ready), 32'd0);
    chk("full_key_ready",   32'(bus.key_ready),   32'd1);
    bus.spawn_valid = 1'b0;
    step();

    // spawn column clamps to COLS-1
    do_reset();
    do_spawn(8'h47, 7'd100);
    wait_idle("clamp");
    chk("clamp_active", 32'(bus.active), 32'd1);

    // tick during a walk queues one more walk; a third tick is dropped
    bus.tick = 1'b1;
    model_walk();
    step();
    bus.tick = 1'b0;
    step();
    bus.tick = 1'b1;
    model_walk();
    step();
    chk("pending_key_ready", 32'(bus.key_ready), 32'd0);
    step();
    bus.tick = 1'b0;
    wait_idle("double_tick");
    repeat (30) step();
    chk("double_tick_queue", 32'(sb.size()), 32'd0);
    chk("double_tick_active", 32'(bus.active), 32'd1);

    // async reset while DRAW is writing
    bus.tick = 1'b1;
    model_walk();
    step();
    bus.tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("draw_wr_en", 32'(bus.wr_en), 32'd1);
    chk("draw_wr_data", 32'(bus.wr_data), 32'h47);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_wr_en",   32'(bus.wr_en),   32'd0);
    chk("arst_wr_data", 32'(bus.wr_data), 32'd0);
    chk("arst_active",  32'(bus.active),  32'd0);
    chk("arst_hit_miss_typo", 32'({bus.hit, bus.miss, bus.typo}), 32'd0);
    chk("arst_queue", 32'(sb.size()), 32'd0);
    step();
    rst = 1'b0;
    model_clear();
    step();
    chk("post_rst_key_ready", 32'(bus.key_ready), 32'd1);
    chk("post_rst_active",    32'(bus.active),    32'd0);
    chk("post_rst_wr_en",     32'(bus.wr_en),     32'd0);
    do_spawn(8'h48, 7'd0);
    wait_idle("post_rst_spawn");
    chk("post_rst_spawn_active", 32'(bus.active), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
